// File: rtl/vp_pixel_serializer.sv
// Pixel output stage: buffers 64-bit words of sixteen 4-bit colour indices and
// hands out one colour index per display request, with a one-cycle output latency.
module vp_pixel_serializer #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         LEVEL_WIDTH = 3,
    parameter logic [3:0] BLANK_COLOR = 4'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [63:0]            pixels,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   pixel_request,
    output logic [3:0]             pixel_color,
    output logic                   pixel_valid,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   ready,
    output logic                   underrun,
    output logic                   overflow
);

    localparam int                     PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LEVEL_WIDTH-1:0] DEPTH_L = LEVEL_WIDTH'(FIFO_DEPTH);

    logic [63:0]            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [LEVEL_WIDTH-1:0] level_reg, level_next;
    logic [63:0]            shift_word_reg;
    logic [3:0]             index_reg, index_next;
    logic                   loaded_reg, loaded_next;
    logic [3:0]             pixel_color_reg, pixel_color_next;
    logic                   pixel_valid_reg, pixel_valid_next;
    logic                   underrun_reg, underrun_next;
    logic                   overflow_reg, overflow_next;

    logic                   not_full, has_word, last_nibble;
    logic                   consume, pop, push, drop;
    logic [3:0]             nibbles [16];

    // Pixel 0 sits in the most significant nibble.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_nibble
            assign nibbles[gi] = shift_word_reg[63-4*gi -: 4];
        end
    endgenerate

    always_comb begin
        not_full    = (level_reg < DEPTH_L);
        has_word    = (level_reg != '0);
        last_nibble = (index_reg == 4'd15);
        consume     = !flush && pixel_request && loaded_reg;
        // Reload when empty, or seamlessly as the last nibble is being consumed.
        pop         = !flush && has_word && (!loaded_reg || (last_nibble && pixel_request));
        push        = !flush && enable && (not_full || pop);
        drop        = !flush && enable && !not_full && !pop;
    end

    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        level_next       = level_reg;
        index_next       = index_reg;
        loaded_next      = loaded_reg;
        pixel_color_next = pixel_color_reg;
        pixel_valid_next = 1'b0;
        underrun_next    = underrun_reg;
        overflow_next    = overflow_reg | drop;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
            index_next  = 4'd0;
            loaded_next = 1'b0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_next = level_reg + 1'b1;
                2'b01:   level_next = level_reg - 1'b1;
                default: level_next = level_reg;
            endcase

            if (pop) begin
                index_next  = 4'd0;
                loaded_next = 1'b1;
            end else if (consume) begin
                index_next = index_reg + 4'd1;
                if (last_nibble) loaded_next = 1'b0;
            end

            if (pixel_request) begin
                pixel_valid_next = 1'b1;
                if (loaded_reg) begin
                    pixel_color_next = nibbles[index_reg];
                end else begin
                    pixel_color_next = BLANK_COLOR;
                    underrun_next    = 1'b1;
                end
            end
        end
    end

    // Storage and shifter data carry no reset; loaded_reg and level_reg gate them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= pixels;
        if (pop)  shift_word_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            index_reg       <= 4'd0;
            loaded_reg      <= 1'b0;
            pixel_color_reg <= BLANK_COLOR;
            pixel_valid_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            level_reg       <= level_next;
            index_reg       <= index_next;
            loaded_reg      <= loaded_next;
            pixel_color_reg <= pixel_color_next;
            pixel_valid_reg <= pixel_valid_next;
            underrun_reg    <= underrun_next;
            overflow_reg    <= overflow_next;
        end
    end

    assign pixel_color = pixel_color_reg;
    assign pixel_valid = pixel_valid_reg;
    assign level       = level_reg;
    assign ready       = not_full;
    assign underrun    = underrun_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_vp_pixel_serializer.sv
// Bench for vp_pixel_serializer: queue-based reference model of the word FIFO and
// the nibble stream, compared against every output on every cycle.
module tb_vp_pixel_serializer;

    localparam int         DEPTH = 4;
    localparam int         LW    = 3;
    localparam logic [3:0] BLANK = 4'd0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [63:0]   pixels = '0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          pixel_request = 1'b0;
    logic [3:0]    pixel_color;
    logic          pixel_valid;
    logic [LW-1:0] level;
    logic          ready;
    logic          underrun;
    logic          overflow;

    int pass_count  = 0;
    int check_count = 0;
    int cycle_no    = 0;

    logic [63:0] m_fifo[$];
    logic [3:0]  m_sh[$];
    logic [3:0]  m_color = BLANK;
    logic        m_valid = 1'b0;
    logic        m_under = 1'b0;
    logic        m_over  = 1'b0;

    vp_pixel_serializer #(
        .FIFO_DEPTH (DEPTH),
        .LEVEL_WIDTH(LW),
        .BLANK_COLOR(BLANK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixels       (pixels),
        .enable       (enable),
        .flush        (flush),
        .pixel_request(pixel_request),
        .pixel_color  (pixel_color),
        .pixel_valid  (pixel_valid),
        .level        (level),
        .ready        (ready),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // {valid, colour, level, ready, underrun, overflow}
    function automatic logic [10:0] obs_vec();
        return {pixel_valid, pixel_color, level, ready, underrun, overflow};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [LW-1:0] lv;
        lv = LW'(m_fifo.size());
        return {m_valid, m_color, lv, (m_fifo.size() < DEPTH), m_under, m_over};
    endfunction

    // Applies one cycle of inputs and advances the reference model by the same cycle.
    task automatic cyc(input logic rst, input logic en, input logic fl,
                       input logic req, input logic [63:0] w);
        int          lvl;
        bit          had, do_pop;
        logic [63:0] w0;
        reset = rst; enable = en; flush = fl; pixel_request = req; pixels = w;
        if (rst) begin
            m_fifo.delete(); m_sh.delete();
            m_color = BLANK; m_valid = 1'b0; m_under = 1'b0; m_over = 1'b0;
        end else if (fl) begin
            m_fifo.delete(); m_sh.delete();
            m_valid = 1'b0;
        end else begin
            lvl    = m_fifo.size();
            had    = (m_sh.size() > 0);
            do_pop = (lvl > 0) && (!had || (m_sh.size() == 1 && req));
            m_valid = req;
            if (req) begin
                if (had) m_color = m_sh.pop_front();
                else begin
                    m_color = BLANK;
                    m_under = 1'b1;
                end
            end
            if (do_pop) begin
                w0 = m_fifo.pop_front();
                for (int i = 0; i < 16; i++) m_sh.push_back(w0[63-4*i -: 4]);
            end
            if (en) begin
                if (lvl < DEPTH || do_pop) m_fifo.push_back(w);
                else m_over = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, '0);
            check_count++;
            if (obs_vec() !== 11'b0_0000_000_1_0_0)
                $display("FAIL reset_idle cycle %0d: got %b required %b", cycle_no, obs_vec(), 11'b0_0000_000_1_0_0);
            else pass_count++;
        end
    endtask

    task automatic test_single_word();
        cyc(0, 1, 0, 0, 64'h0123_4567_89AB_CDEF);
        cyc(0, 0, 0, 0, '0);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 0, 0, 1, '0);
            check_count++;
            if (obs_vec() !== exp_vec())
                $display("FAIL single_word cycle %0d: got %b required %b", cycle_no, obs_vec(), exp_vec());
            else pass_count++;
            if (i < 16) begin
                check_count++;
                if (pixel_color !== i[3:0] || pixel_valid !== 1'b1)
                    $display("FAIL single_word_colour pixel %0d: got %h/%b required %h/1", i, pixel_color, pixel_valid, i[3:0]);
                else pass_count++;
            end
        end
        check_count++;
        if ({pixel_valid, pixel_color, underrun} !== {1'b1, BLANK, 1'b1})
            $display("FAIL single_word_underrun: got %b required %b", {pixel_valid, pixel_color, underrun}, {1'b1, BLANK, 1'b1});
        else pass_count++;
        cyc(0, 0, 0, 0, '0);
    endtask

    task automatic test_overflow();
        logic [63:0] w;
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) begin
            w = {$urandom, $urandom};
            cyc(0, 1, 0, 0, w);
            check_count++;
            if (obs_vec() !== exp_vec())
                $display("FAIL overflow_fill cycle %0d: got %b required %b", cycle_no, obs_vec(), exp_vec());
            else pass_count++;
        end
        check_count++;
        if ({level, ready, overflow} !== {3'd4, 1'b0, 1'b1})
            $display("FAIL overflow_full: got %b required %b", {level, ready, overflow}, {3'd4, 1'b0, 1'b1});
        else pass_count++;
        for (int i = 0; i < 80; i++) begin
            cyc(0, 0, 0, 1, '0);
            check_count++;
            if (obs_vec() !== exp_vec() || pixel_valid !== 1'b1 || underrun !== 1'b0)
                $display("FAIL overflow_drain cycle %0d: got %b required %b", cycle_no, obs_vec(), exp_vec());
            else pass_count++;
        end
        cyc(0, 0, 0, 0, '0);
    endtask

    task automatic test_steady();
        cyc(1, 0, 0, 0, '0);
        for (int c = 0; c < 132; c++) begin
            cyc(0, (c % 16 == 0) && (c < 128), 0, (c >= 2) && (c < 130), {$urandom, $urandom});
            check_count++;
            if (obs_vec() !== exp_vec() || level > 3'd1)
                $display("FAIL steady cycle %0d: got %b required %b", cycle_no, obs_vec(), exp_vec());
            else pass_count++;
        end
        check_count++;
        if (underrun !== 1'b0)
            $display("FAIL steady_underrun: got %b required 0", underrun);
        else pass_count++;
    endtask

    task automatic test_flush();
        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, {$urandom, $urandom});
        cyc(0, 1, 0, 0, {$urandom, $urandom});
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, '0);
        cyc(0, 1, 1, 1, {$urandom, $urandom});
        check_count++;
        if ({pixel_valid, level, overflow} !== 5'b0_000_0 || obs_vec() !== exp_vec())
            $display("FAIL flush_state: got %b required %b", obs_vec(), exp_vec());
        else pass_count++;
        cyc(0, 0, 0, 1, '0);
        check_count++;
        if ({pixel_valid, pixel_color, underrun, overflow} !== {1'b1, BLANK, 1'b1, 1'b0} || obs_vec() !== exp_vec())
            $display("FAIL flush_blank: got %b required %b", obs_vec(), exp_vec());
        else pass_count++;
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, {$urandom, $urandom});
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, '0);
        check_count++;
        if (level !== 3'd3 || obs_vec() !== exp_vec())
            $display("FAIL reset_mid_setup: got %b required %b", obs_vec(), exp_vec());
        else pass_count++;
        cyc(1, 0, 0, 1, '0);
        check_count++;
        if (obs_vec() !== 11'b0_0000_000_1_0_0)
            $display("FAIL reset_mid_state: got %b required %b", obs_vec(), 11'b0_0000_000_1_0_0);
        else pass_count++;
        test_single_word();
    endtask

    task automatic test_random();
        logic en, fl, req;
        cyc(1, 0, 0, 0, '0);
        for (int c = 0; c < 2000; c++) begin
            en  = ($urandom_range(0, 15) < 2);
            fl  = ($urandom_range(0, 63) == 0);
            req = ($urandom_range(0, 3) != 0);
            cyc(0, en, fl, req, {$urandom, $urandom});
            check_count++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random cycle %0d: got %b required %b", cycle_no, obs_vec(), exp_vec());
            else pass_count++;
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_overflow();
        test_steady();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/vp_pixel_serializer.md
Name: vp_pixel_serializer

Overview:
- Downstream end of the video pipeline's pixel output.
- Accepts 64-bit pixel words (16 pixels × 4-bit colour index), each marked by a one-cycle `enable` strobe, and buffers them in a small FIFO.
- Emits one 4-bit colour index per `pixel_request` from the display timing generator.
- Reports FIFO level and ready so the character fetcher can throttle, and flags underrun and overflow for debug.

Parameters:
- FIFO_DEPTH, 4, number of 64-bit words buffered (power of two, 2..16).
- LEVEL_WIDTH, 3, width of `level` output; must hold 0..FIFO_DEPTH.
- BLANK_COLOR, 4'd0, colour emitted on underrun and during reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pixels  input  64  pixel word; pixel 0 (leftmost) = bits [63:60], pixel 15 = bits [3:0]
- enable  input  1  write strobe; `pixels` valid this cycle
- flush  input  1  discard all buffered pixels (line/frame restart)
- pixel_request  input  1  consume one pixel this cycle
- pixel_color  output  4  colour index of the consumed pixel
- pixel_valid  output  1  `pixel_color` corresponds to a request made the previous cycle
- level  output  LEVEL_WIDTH  words held in FIFO, excluding the word in the shifter
- ready  output  1  high when level < FIFO_DEPTH
- underrun  output  1  sticky; a request found no pixel available
- overflow  output  1  sticky; a write was dropped

Behaviour:
- Reset (synchronous, active-high):
  - FIFO pointers = 0, level = 0, ready = 1.
  - Shifter empty, nibble index = 0.
  - pixel_color = BLANK_COLOR, pixel_valid = 0, underrun = 0, overflow = 0.
  - Reset mid-line discards everything.
- FIFO storage: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - level increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Shifter: holds one word, a 4-bit nibble index and a loaded flag.
- Shifter load (pop): occurs in any cycle where either condition holds:
  - the shifter is empty and level > 0; or
  - the shifter is loaded, index = 15, pixel_request = 1 and level > 0 (seamless back-to-back).
  - On load, the index is set to 0.
- Shifter drain: if index = 15 is consumed and level = 0, the shifter becomes empty.
- Push:
  - enable = 1 and (level < FIFO_DEPTH, or a pop occurs the same cycle): the word is written, level updates next cycle.
  - enable = 1 while full with no pop: word dropped, overflow set.
- Request with shifter loaded:
  - Next cycle: pixel_color = word[63-4*index -: 4], pixel_valid = 1.
  - index increments.
  - Output latency is exactly 1 cycle.
- Request with shifter empty (including the same cycle the shifter is loading):
  - Next cycle: pixel_color = BLANK_COLOR, pixel_valid = 1, underrun set.
  - The load in progress is not consumed.
- No request: pixel_valid = 0 next cycle and pixel_color holds its last value.
- Latency:
  - enable at cycle T → level = 1 at T+1.
  - Shifter loaded at T+2, level = 0.
  - Earliest valid pixel request at T+2, with output at T+3.
  - With sustained writes, pixel_request may be held high indefinitely with no gaps, provided FIFO_DEPTH ≥ 2 and the writer keeps level > 0.
- Flush:
  - Takes priority over enable and pixel_request in the same cycle; the write in that cycle is dropped but does not set overflow.
  - Next cycle: level = 0, shifter empty, pixel_valid = 0.
  - underrun and overflow are not cleared; only reset clears them.
- `ready` is combinational from level. The writer must not rely on it to cover a same-cycle pop.

Test Plan:
- Reset then idle → pixel_color = 0, pixel_valid = 0, level = 0, ready = 1, flags = 0.
- Write 64'h0123_4567_89AB_CDEF at T; request held high from T+2 for 16 cycles → colours 0,1,…,F on T+3..T+18 with pixel_valid = 1; request at T+18 → BLANK_COLOR and underrun = 1.
- Write 5 words back-to-back with no requests (FIFO_DEPTH = 4) → first word moves to the shifter; level reaches 4, ready = 0; sixth write dropped, overflow = 1; 80 continuous requests then return all 5 words in order with no gap at word boundaries.
- Steady state: one write every 16 cycles, request every cycle → pixel stream unbroken, level oscillates 0..1, underrun stays 0.
- Mid-word flush after 5 pixels consumed, with enable asserted the same cycle → next cycle level = 0, pixel_valid = 0; following request yields BLANK_COLOR; overflow stays 0.
- Reset asserted with level = 3 and shifter at index 7 → next cycle all state matches the reset values; subsequent write/request sequence behaves as in the second scenario.
